// File: rtl/tpu_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_ram_pkg
// Purpose  : Shared widths and FSM state encoding for the RAM fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tpu_ram_pkg;

  localparam int AWIDTH            = 10;
  localparam int DWIDTH            = 8;
  localparam int DESIGN_SIZE       = 32;
  localparam int ADDR_STRIDE_WIDTH = 16;
  localparam int NUM_ROWS_W        = 6;
  localparam int ROW_IDX_W         = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/ram_fetch_sequencer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ram_addr_gen
// Purpose  : Row address accumulator and row counter with last-row flag.
// Revision : 1.0 - initial release
// ============================================================================
module ram_addr_gen #(
  parameter int AWIDTH     = tpu_ram_pkg::AWIDTH,
  parameter int NUM_ROWS_W = tpu_ram_pkg::NUM_ROWS_W,
  parameter int ROW_IDX_W  = tpu_ram_pkg::ROW_IDX_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  step,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [AWIDTH-1:0]     stride,
  input  logic [NUM_ROWS_W-1:0] num_rows,
  output logic [AWIDTH-1:0]     addr,
  output logic [ROW_IDX_W-1:0]  row,
  output logic                  last_row
);

  logic [AWIDTH-1:0]    addr_q, addr_d;
  logic [AWIDTH-1:0]    stride_q, stride_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic [ROW_IDX_W-1:0] last_idx_q, last_idx_d;

  always_comb begin
    addr_d     = addr_q;
    stride_d   = stride_q;
    row_d      = row_q;
    last_idx_d = last_idx_q;
    if (load) begin
      addr_d     = base_addr;
      stride_d   = stride;
      row_d      = '0;
      // num_rows=32 maps to index 31; num_rows=0 never reaches this counter
      last_idx_d = ROW_IDX_W'(num_rows - NUM_ROWS_W'(1));
    end else if (step) begin
      addr_d = addr_q + stride_q;
      row_d  = row_q + ROW_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      last_idx_q <= '0;
    end else begin
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      last_idx_q <= last_idx_d;
    end
  end

  assign addr     = addr_q;
  assign row      = row_q;
  assign last_row = (row_q == last_idx_q);

endmodule
`default_nettype wire

// File: rtl/ram_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_fetch_sequencer
// Purpose  : Strided row fetch from a shared RAM port, with host arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module ram_fetch_sequencer #(
  parameter int AWIDTH            = tpu_ram_pkg::AWIDTH,
  parameter int DWIDTH            = tpu_ram_pkg::DWIDTH,
  parameter int DESIGN_SIZE       = tpu_ram_pkg::DESIGN_SIZE,
  parameter int ADDR_STRIDE_WIDTH = tpu_ram_pkg::ADDR_STRIDE_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [AWIDTH-1:0]             base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]  stride,
  input  logic [5:0]                    num_rows,
  output logic                          busy,
  output logic                          done,
  output logic [AWIDTH-1:0]             ram_addr,
  output logic [DESIGN_SIZE-1:0]        ram_we,
  output logic [DESIGN_SIZE*DWIDTH-1:0] ram_d,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] ram_q,
  output logic [DESIGN_SIZE*DWIDTH-1:0] row_data,
  output logic                          row_valid,
  output logic [4:0]                    row_idx,
  input  logic                          host_req,
  input  logic [AWIDTH-1:0]             host_addr,
  input  logic [DESIGN_SIZE-1:0]        host_we,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] host_wdata,
  output logic                          host_gnt
);

  import tpu_ram_pkg::*;

  fetch_state_e state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         row_valid_q, row_valid_d;
  logic [4:0]   row_idx_q, row_idx_d;

  logic              ag_load;
  logic              ag_step;
  logic [AWIDTH-1:0] ag_addr;
  logic [4:0]        ag_row;
  logic              ag_last;
  logic [AWIDTH-1:0] stride_lo;
  logic              fetch_own;

  // Only the low address bits of the stride matter; the accumulator wraps mod 2^AWIDTH
  assign stride_lo = AWIDTH'(stride);

  if (ADDR_STRIDE_WIDTH > AWIDTH) begin : g_stride_hi
    logic unused_stride_hi;
    assign unused_stride_hi = ^stride[ADDR_STRIDE_WIDTH-1:AWIDTH];
  end

  ram_addr_gen #(
    .AWIDTH     (AWIDTH),
    .NUM_ROWS_W (6),
    .ROW_IDX_W  (5)
  ) u_addr_gen (
    .clk       (clk),
    .resetn    (resetn),
    .load      (ag_load),
    .step      (ag_step),
    .base_addr (base_addr),
    .stride    (stride_lo),
    .num_rows  (num_rows),
    .addr      (ag_addr),
    .row       (ag_row),
    .last_row  (ag_last)
  );

  always_comb begin
    state_d = state_q;
    ag_load = 1'b0;
    ag_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          state_d = (num_rows == 6'd0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        ag_step = 1'b1;
        if (ag_last) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    // Read data returns one cycle after issue, so valid/index trail the read by one flop
    row_valid_d = (state_q == FETCH);
    row_idx_d   = (state_q == FETCH) ? ag_row : 5'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
    end
  end

  assign fetch_own = (state_q == FETCH);
  assign host_gnt  = host_req & ~fetch_own;

  always_comb begin
    ram_addr = '0;
    ram_we   = '0;
    ram_d    = '0;
    if (fetch_own) begin
      ram_addr = ag_addr;
    end else if (host_gnt) begin
      ram_addr = host_addr;
      ram_we   = host_we;
      ram_d    = host_wdata;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign row_valid = row_valid_q;
  assign row_idx   = row_idx_q;
  assign row_data  = row_valid_q ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fetch_sequencer
// Purpose  : Directed scoreboard bench for ram_fetch_sequencer with a RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fetch_sequencer;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DS = 32;
  localparam int SW = 16;
  localparam int RW = DS * DW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] stride;
  logic [5:0]    num_rows;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [DS-1:0] ram_we;
  logic [RW-1:0] ram_d, ram_q, row_data;
  logic          row_valid;
  logic [4:0]    row_idx;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic [DS-1:0] host_we;
  logic [RW-1:0] host_wdata;
  logic          host_gnt;

  always #5 clk = ~clk;

  ram_fetch_sequencer #(
    .AWIDTH(AW), .DWIDTH(DW), .DESIGN_SIZE(DS), .ADDR_STRIDE_WIDTH(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .stride(stride), .num_rows(num_rows), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q),
    .row_data(row_data), .row_valid(row_valid), .row_idx(row_idx),
    .host_req(host_req), .host_addr(host_addr), .host_we(host_we),
    .host_wdata(host_wdata), .host_gnt(host_gnt)
  );

  function automatic logic [RW-1:0] pat(input int a);
    logic [RW-1:0] p;
    for (int j = 0; j < DS; j++) p[j*DW +: DW] = 8'((a * 5 + j * 29 + 7) & 255);
    return p;
  endfunction

  // RAM model: synchronous read, per-element write enables
  logic [RW-1:0] mem [0:1023];
  initial begin
    for (int a = 0; a < 1024; a++) mem[a] <= pat(a);
  end
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    for (int j = 0; j < DS; j++)
      if (ram_we[j]) mem[ram_addr][j*DW +: DW] <= ram_d[j*DW +: DW];
  end

  localparam logic [AW-1:0] WR_ADDR = 10'h100;
  localparam logic [DS-1:0] WR_WE   = 32'h0F0F_F0F0;
  localparam logic [RW-1:0] WR_DATA = {DS{8'hA5}};
  logic wrote = 1'b0;

  function automatic logic [RW-1:0] exp_mem(input logic [AW-1:0] a);
    logic [RW-1:0] v;
    v = pat(int'(a));
    if (wrote && a == WR_ADDR)
      for (int j = 0; j < DS; j++) if (WR_WE[j]) v[j*DW +: DW] = 8'hA5;
    return v;
  endfunction

  typedef struct packed {
    logic [RW-1:0] data;
    logic [4:0]    idx;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int dones = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (done) dones++;
    if (row_valid) begin
      if (sbq.size() == 0) begin
        chk("row_valid_unexpected", RW'(row_valid), '0);
      end else begin
        e = sbq.pop_front();
        chk("row_data", row_data, e.data);
        chk("row_idx", RW'(row_idx), RW'(e.idx));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, RW'(busy), '0);
    chk({tag, "_done"}, RW'(done), '0);
    chk({tag, "_row_valid"}, RW'(row_valid), '0);
    chk({tag, "_row_idx"}, RW'(row_idx), '0);
    chk({tag, "_row_data"}, row_data, '0);
    chk({tag, "_ram_addr"}, RW'(ram_addr), '0);
    chk({tag, "_ram_we"}, RW'(ram_we), '0);
    chk({tag, "_ram_d"}, ram_d, '0);
  endtask

  task automatic run_fetch(input logic [AW-1:0] b, input logic [SW-1:0] s, input int n,
                           input logic hreq, input logic early, input logic [AW-1:0] ha,
                           input logic [DS-1:0] hw, input logic [RW-1:0] hd, input logic hold);
    int            last;
    int            d0;
    logic [AW-1:0] s_lo;
    logic [AW-1:0] a;
    exp_t          e;
    s_lo = s[AW-1:0];
    last = (n == 0) ? 1 : n + 2;
    for (int k = 0; k < n; k++) begin
      e.data = exp_mem(AW'(int'(b) + k * int'(s_lo)));
      e.idx  = 5'(k);
      sbq.push_back(e);
    end
    base_addr = b; stride = s; num_rows = 6'(n); start = 1'b1;
    host_addr = ha; host_we = hw; host_wdata = hd;
    host_req  = hreq & early;
    #1;
    if (hreq && early) chk("host_gnt_with_start", RW'(host_gnt), RW'(1));
    d0 = dones;
    for (int c = 1; c <= last; c++) begin
      step();
      if (!hold || c == last) start = 1'b0;
      host_req  = hreq;
      base_addr = AW'($urandom);
      stride    = SW'($urandom);
      num_rows  = 6'($urandom_range(1, 32));
      #1;
      a = AW'(int'(b) + (c - 1) * int'(s_lo));
      chk("busy", RW'(busy), RW'(1));
      chk("done", RW'(done), RW'(c == last));
      chk("row_valid", RW'(row_valid), RW'(n > 0 && c >= 2 && c <= n + 1));
      chk("host_gnt", RW'(host_gnt), RW'(hreq && c > n));
      if (c <= n) begin
        chk("ram_addr_read", RW'(ram_addr), RW'(a));
        chk("ram_we_read", RW'(ram_we), '0);
      end else if (hreq) begin
        chk("ram_addr_host", RW'(ram_addr), RW'(ha));
        chk("ram_we_host", RW'(ram_we), RW'(hw));
        chk("ram_d_host", ram_d, hd);
      end else begin
        chk("ram_addr_idle", RW'(ram_addr), '0);
        chk("ram_we_idle", RW'(ram_we), '0);
      end
    end
    step();
    chk("busy_after", RW'(busy), '0);
    chk("done_after", RW'(done), '0);
    chk("one_done_per_start", RW'(dones - d0), RW'(1));
    chk("scoreboard_drained", RW'(sbq.size()), '0);
  endtask

  initial begin
    int   d0;
    exp_t e;
    resetn = 1'b0; start = 1'b0; base_addr = '0; stride = '0; num_rows = '0;
    host_req = 1'b0; host_addr = '0; host_we = '0; host_wdata = '0;
    #2;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    chk("idle_busy", RW'(busy), '0);

    run_fetch(10'h010, 16'd32, 4, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    run_fetch(10'h3F0, 16'd16, 3, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    run_fetch(10'h000, 16'd5, 0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    run_fetch(10'h123, 16'hFC07, 5, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    // Host held across a fetch that reads the write target before the write lands
    run_fetch(10'h0F0, 16'd4, 8, 1'b1, 1'b0, WR_ADDR, WR_WE, WR_DATA, 1'b0);
    host_req = 1'b0;
    wrote = 1'b1;
    step();
    run_fetch(WR_ADDR, 16'd0, 2, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    run_fetch(10'h200, 16'd1, 2, 1'b1, 1'b1, 10'h3AA, '0, {DS{8'h5A}}, 1'b0);
    host_req = 1'b0;
    step();

    run_fetch(10'h040, 16'd8, 3, 1'b0, 1'b0, '0, '0, '0, 1'b1);

    // Reset in cycle 3 of a 10-row fetch
    for (int k = 0; k < 2; k++) begin
      e.data = exp_mem(AW'(10'h050 + k * 3));
      e.idx  = 5'(k);
      sbq.push_back(e);
    end
    base_addr = 10'h050; stride = 16'd3; num_rows = 6'd10; start = 1'b1;
    d0 = dones;
    step();
    start = 1'b0;
    step();
    step();
    resetn = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    chk("reset_held_busy", RW'(busy), '0);
    resetn = 1'b1;
    repeat (6) step();
    chk("no_done_after_abort", RW'(dones - d0), '0);
    chk("idle_after_abort", RW'(busy), '0);
    chk("abort_rows_consumed", RW'(sbq.size()), '0);

    run_fetch(10'h300, 16'd2, 32, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
